// File: rtl/vector_fetch.sv
// rtl/vector_fetch.sv - AVG display-list fetch and flow-control engine
module vector_fetch #(
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vggo,
    input  logic            vgrst,
    output logic [PC_W:0]   memAddr,
    input  logic [7:0]      memData,
    output logic [31:0]     instr,
    output logic            instrLen2,
    output logic            instrValid,
    input  logic            instrReady,
    output logic            halted,
    output logic            stackErr
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_VCTR = 3'b000;
    localparam logic [2:0] OP_HALT = 3'b001;
    localparam logic [2:0] OP_JSRL = 3'b101;
    localparam logic [2:0] OP_RTSL = 3'b110;
    localparam logic [2:0] OP_JMPL = 3'b111;

    typedef enum logic [2:0] {
        IDLE, F_LO, F_HI, F_CAP, F2_LO, F2_HI, F2_CAP, EMIT
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nx;
    logic [PC_W-1:0]  w_pc_inc;
    logic [PC_W-1:0]  w_target;
    logic [SP_W-1:0]  r_sp;
    logic [SP_W-1:0]  w_sp_nx;
    logic [SP_W-1:0]  w_sp_dec;
    logic [IDX_W-1:0] w_push_idx;
    logic [IDX_W-1:0] w_pop_idx;
    logic [PC_W-1:0]  r_stack [STACK_DEPTH];
    logic [PC_W:0]    r_mem_addr;
    logic [PC_W:0]    w_addr_nx;
    logic [7:0]       r_lo;
    logic [15:0]      w_word;
    logic [15:0]      r_word1;
    logic [31:0]      r_instr;
    logic             r_len2;
    logic             r_halted;
    logic             r_stack_err;
    logic             w_push;
    logic             w_err_set;
    logic             w_load1;
    logic             w_load2;
    logic             w_word1_cap;

    // The word being decoded: high byte arrives this clk, low byte was captured last clk.
    assign w_word     = {memData, r_lo};
    assign w_target   = w_word[PC_W-1:0];
    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_sp_dec   = r_sp - SP_W'(1);
    assign w_push_idx = r_sp[IDX_W-1:0];
    assign w_pop_idx  = w_sp_dec[IDX_W-1:0];

    assign memAddr    = r_mem_addr;
    assign instr      = r_instr;
    assign instrLen2  = r_len2;
    assign instrValid = (r_state == EMIT);
    assign halted     = r_halted;
    assign stackErr   = r_stack_err;

    // Next-state, pc/sp update and decode of flow-control opcodes; vgrst overrides everything.
    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_sp_nx     = r_sp;
        w_push      = 1'b0;
        w_err_set   = 1'b0;
        w_load1     = 1'b0;
        w_load2     = 1'b0;
        w_word1_cap = 1'b0;
        case (r_state)
            IDLE: begin
                if (vggo) begin
                    w_state_nx = F_LO;
                    w_pc_nx    = '0;
                    w_sp_nx    = '0;
                end
            end
            F_LO:  w_state_nx = F_HI;
            F_HI:  w_state_nx = F_CAP;
            F_CAP: begin
                w_pc_nx = w_pc_inc;
                case (w_word[15:13])
                    OP_HALT: w_state_nx = IDLE;
                    OP_JMPL: begin
                        w_pc_nx    = w_target;
                        w_state_nx = F_LO;
                    end
                    OP_JSRL: begin
                        if (r_sp == SP_W'(STACK_DEPTH)) begin
                            w_err_set  = 1'b1;
                            w_state_nx = IDLE;
                        end else begin
                            w_push     = 1'b1;
                            w_pc_nx    = w_target;
                            w_sp_nx    = r_sp + SP_W'(1);
                            w_state_nx = F_LO;
                        end
                    end
                    OP_RTSL: begin
                        if (r_sp == '0) begin
                            w_err_set  = 1'b1;
                            w_state_nx = IDLE;
                        end else begin
                            w_pc_nx    = r_stack[w_pop_idx];
                            w_sp_nx    = w_sp_dec;
                            w_state_nx = F_LO;
                        end
                    end
                    OP_VCTR: begin
                        w_word1_cap = 1'b1;
                        w_state_nx  = F2_LO;
                    end
                    default: begin
                        w_load1    = 1'b1;
                        w_state_nx = EMIT;
                    end
                endcase
            end
            F2_LO: w_state_nx = F2_HI;
            F2_HI: w_state_nx = F2_CAP;
            F2_CAP: begin
                w_pc_nx    = w_pc_inc;
                w_load2    = 1'b1;
                w_state_nx = EMIT;
            end
            EMIT: begin
                if (instrReady) begin
                    w_state_nx = F_LO;
                end
            end
            default: w_state_nx = IDLE;
        endcase
        if (vgrst) begin
            w_state_nx  = IDLE;
            w_pc_nx     = '0;
            w_sp_nx     = '0;
            w_push      = 1'b0;
            w_err_set   = 1'b0;
            w_load1     = 1'b0;
            w_load2     = 1'b0;
            w_word1_cap = 1'b0;
        end
    end

    // The registered byte address is set up one clk ahead so it is on the port during F_LO/F_HI.
    always_comb begin
        w_addr_nx = r_mem_addr;
        case (w_state_nx)
            F_LO, F2_LO: w_addr_nx = {w_pc_nx, 1'b0};
            F_HI, F2_HI: w_addr_nx = {r_pc, 1'b1};
            default:     w_addr_nx = r_mem_addr;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_sp        <= '0;
            r_mem_addr  <= '0;
            r_lo        <= '0;
            r_word1     <= '0;
            r_instr     <= '0;
            r_len2      <= 1'b0;
            r_halted    <= 1'b1;
            r_stack_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_sp       <= w_sp_nx;
            r_mem_addr <= w_addr_nx;
            r_halted   <= (w_state_nx == IDLE);
            if (r_state == F_HI || r_state == F2_HI) begin
                r_lo <= memData;
            end
            if (w_word1_cap) begin
                r_word1 <= w_word;
            end
            if (w_load1) begin
                r_instr <= {16'h0000, w_word};
                r_len2  <= 1'b0;
            end else if (w_load2) begin
                r_instr <= {w_word, r_word1};
                r_len2  <= 1'b1;
            end
            if (vgrst) begin
                r_stack_err <= 1'b0;
            end else if (w_err_set) begin
                r_stack_err <= 1'b1;
            end
        end
    end

    // Return-address storage; contents are only meaningful below sp so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end
endmodule

// File: tb/tb_vector_fetch.sv
// tb/tb_vector_fetch.sv - directed self-checking bench for vector_fetch
module tb_vector_fetch;
    localparam int PC_W        = 12;
    localparam int STACK_DEPTH = 4;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [31:0] exp_instr;
        logic        exp_len2;
        int          exp_lat;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            vggo = 1'b0;
    logic            vgrst = 1'b0;
    logic            instrReady = 1'b0;
    logic [PC_W:0]   memAddr;
    logic [7:0]      memData;
    logic [31:0]     instr;
    logic            instrLen2;
    logic            instrValid;
    logic            halted;
    logic            stackErr;
    logic [7:0]      mem [0:8191];
    int              checks = 0;
    int              errors = 0;
    int              xfers = 0;
    vec_t            tbl [6];
    logic [PC_W:0]   exp_addr [8];
    logic [PC_W:0]   alog [$];

    vector_fetch #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk(clk), .rst(rst), .vggo(vggo), .vgrst(vgrst),
        .memAddr(memAddr), .memData(memData),
        .instr(instr), .instrLen2(instrLen2), .instrValid(instrValid),
        .instrReady(instrReady), .halted(halted), .stackErr(stackErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) memData <= mem[memAddr];

    always @(posedge clk) if (!rst && instrValid && instrReady) xfers++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            mem[2*i]   = 8'h00;
            mem[2*i+1] = 8'h20;
        end
    endtask

    task automatic set_word(input int a, input logic [15:0] w);
        mem[2*a]   = w[7:0];
        mem[2*a+1] = w[15:8];
    endtask

    task automatic go();
        vggo = 1'b1;
        tick();
        vggo = 1'b0;
    endtask

    task automatic do_vgrst();
        vgrst = 1'b1;
        tick();
        vgrst = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instrValid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        while (!halted && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int   n;
        int   x0;
        int   cnt;
        logic sawv;
        logic [31:0] seen;

        tbl[0] = '{16'h4123, 16'h2000, 16'h2000, 32'h00004123, 1'b0, 3};
        tbl[1] = '{16'h6ABC, 16'h2000, 16'h2000, 32'h00006ABC, 1'b0, 3};
        tbl[2] = '{16'h8000, 16'h2000, 16'h2000, 32'h00008000, 1'b0, 3};
        tbl[3] = '{16'h5FFF, 16'h2000, 16'h2000, 32'h00005FFF, 1'b0, 3};
        tbl[4] = '{16'h0010, 16'h1F20, 16'h2000, 32'h1F200010, 1'b1, 6};
        tbl[5] = '{16'h1FFF, 16'hFFFF, 16'h2000, 32'hFFFF1FFF, 1'b1, 6};
        exp_addr = '{13'd0, 13'd1, 13'd8, 13'd9, 13'd10, 13'd11, 13'd2, 13'd3};

        clear_mem();
        tick();
        chk("rst_memAddr", 32'(memAddr), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_len2", 32'(instrLen2), 32'h0);
        chk("rst_valid", 32'(instrValid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h1);
        chk("rst_stackErr", 32'(stackErr), 32'h0);
        rst = 1'b0;
        tick();

        // HALT only: halted low for exactly the one-word fetch
        set_word(0, 16'h2000);
        go();
        cnt = 0;
        sawv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!halted) cnt++;
            if (instrValid) sawv = 1'b1;
            tick();
        end
        chk("halt_low_clks", 32'(cnt), 32'd3);
        chk("halt_no_valid", 32'(sawv), 32'h0);
        chk("halt_final", 32'(halted), 32'h1);

        // table of single draw ops with ready held high
        instrReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clear_mem();
            set_word(0, tbl[i].w0);
            set_word(1, tbl[i].w1);
            set_word(2, tbl[i].w2);
            x0 = xfers;
            go();
            wait_valid(n);
            chk($sformatf("t%0d_latency", i), 32'(n), 32'(tbl[i].exp_lat));
            chk($sformatf("t%0d_instr", i), instr, tbl[i].exp_instr);
            chk($sformatf("t%0d_len2", i), 32'(instrLen2), 32'(tbl[i].exp_len2));
            wait_halt(n);
            chk($sformatf("t%0d_halted", i), 32'(halted), 32'h1);
            chk($sformatf("t%0d_xfers", i), 32'(xfers - x0), 32'd1);
        end

        // VCTR with 5-clk stall; a vggo mid-stall must be ignored
        clear_mem();
        set_word(0, 16'h0010);
        set_word(1, 16'h1F20);
        set_word(2, 16'h2000);
        instrReady = 1'b0;
        x0 = xfers;
        go();
        wait_valid(n);
        chk("stall_latency", 32'(n), 32'd6);
        for (int i = 0; i < 5; i++) begin
            vggo = (i == 2);
            chk($sformatf("stall_instr_%0d", i), instr, 32'h1F200010);
            chk($sformatf("stall_valid_%0d", i), 32'(instrValid), 32'h1);
            chk($sformatf("stall_len2_%0d", i), 32'(instrLen2), 32'h1);
            tick();
        end
        vggo = 1'b0;
        instrReady = 1'b1;
        chk("stall_release_instr", instr, 32'h1F200010);
        tick();
        wait_halt(n);
        chk("stall_xfers", 32'(xfers - x0), 32'd1);
        chk("stall_halted", 32'(halted), 32'h1);

        // JSRL / RTSL round trip and address trace
        clear_mem();
        set_word(0, 16'hA004);
        set_word(1, 16'h2000);
        set_word(4, 16'h8001);
        set_word(5, 16'hC000);
        x0 = xfers;
        seen = 32'h0;
        alog.delete();
        go();
        for (int i = 0; i < 40 && !halted; i++) begin
            if (alog.size() == 0 || memAddr != alog[$]) alog.push_back(memAddr);
            if (instrValid) seen = instr;
            tick();
        end
        chk("jsr_trace_len", 32'(alog.size()), 32'd8);
        for (int k = 0; k < 8 && k < alog.size(); k++) begin
            chk($sformatf("jsr_addr_%0d", k), 32'(alog[k]), 32'(exp_addr[k]));
        end
        chk("jsr_instr", seen, 32'h00008001);
        chk("jsr_xfers", 32'(xfers - x0), 32'd1);
        chk("jsr_stackErr", 32'(stackErr), 32'h0);
        chk("jsr_halted", 32'(halted), 32'h1);

        // stack overflow from a self-recursive JSRL
        clear_mem();
        set_word(0, 16'hA000);
        go();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!halted) cnt++;
            tick();
        end
        chk("ovf_low_clks", 32'(cnt), 32'd15);
        chk("ovf_stackErr", 32'(stackErr), 32'h1);
        chk("ovf_halted", 32'(halted), 32'h1);
        set_word(0, 16'h2000);
        go();
        wait_halt(n);
        tick();
        chk("ovf_sticky_after_vggo", 32'(stackErr), 32'h1);
        do_vgrst();
        chk("ovf_cleared_by_vgrst", 32'(stackErr), 32'h0);

        // stack underflow from a bare RTSL
        set_word(0, 16'hC000);
        go();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!halted) cnt++;
            tick();
        end
        chk("unf_low_clks", 32'(cnt), 32'd3);
        chk("unf_stackErr", 32'(stackErr), 32'h1);
        do_vgrst();
        chk("unf_cleared", 32'(stackErr), 32'h0);

        // vgrst during F_HI, then restart
        clear_mem();
        set_word(0, 16'h4123);
        set_word(1, 16'h2000);
        x0 = xfers;
        go();
        tick();
        chk("fhi_addr", 32'(memAddr), 32'h1);
        do_vgrst();
        chk("fhi_rst_valid", 32'(instrValid), 32'h0);
        chk("fhi_rst_halted", 32'(halted), 32'h1);
        chk("fhi_rst_addr_hold", 32'(memAddr), 32'h1);
        tick();
        chk("fhi_stays_idle", 32'(halted), 32'h1);
        go();
        chk("fhi_restart_addr", 32'(memAddr), 32'h0);
        chk("fhi_restart_halted", 32'(halted), 32'h0);
        wait_valid(n);
        chk("fhi_restart_instr", instr, 32'h00004123);
        wait_halt(n);
        chk("fhi_restart_xfers", 32'(xfers - x0), 32'd1);

        // vgrst during a stalled EMIT drops the instruction
        instrReady = 1'b0;
        x0 = xfers;
        go();
        wait_valid(n);
        chk("emit_latency", 32'(n), 32'd3);
        tick();
        tick();
        do_vgrst();
        chk("emit_rst_valid", 32'(instrValid), 32'h0);
        chk("emit_rst_halted", 32'(halted), 32'h1);
        chk("emit_rst_xfers", 32'(xfers - x0), 32'd0);
        instrReady = 1'b1;
        go();
        chk("emit_restart_addr", 32'(memAddr), 32'h0);
        wait_valid(n);
        chk("emit_restart_instr", instr, 32'h00004123);
        wait_halt(n);
        chk("emit_restart_xfers", 32'(xfers - x0), 32'd1);

        // vgrst wins over a simultaneous vggo
        vggo = 1'b1;
        vgrst = 1'b1;
        tick();
        vggo = 1'b0;
        vgrst = 1'b0;
        chk("rst_wins_halted", 32'(halted), 32'h1);
        tick();
        chk("rst_wins_still_idle", 32'(halted), 32'h1);

        // JMPL to the last word; pc wraps to 0 after it
        clear_mem();
        set_word(0, 16'hEFFF);
        set_word(4095, 16'h4555);
        instrReady = 1'b0;
        go();
        wait_valid(n);
        chk("wrap_latency", 32'(n), 32'd6);
        chk("wrap_instr", instr, 32'h00004555);
        chk("wrap_addr_last", 32'(memAddr), 32'h1FFF);
        instrReady = 1'b1;
        tick();
        instrReady = 1'b0;
        chk("wrap_addr_zero", 32'(memAddr), 32'h0);
        chk("wrap_valid_drop", 32'(instrValid), 32'h0);
        do_vgrst();
        chk("wrap_halted", 32'(halted), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
